// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
// Holds the state encoding, the opcodes the controller understands, and the
// encodings of alu_op, alu_src_b and pc_source, plus the packed control word
// that the FSM registers each cycle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_HALT      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control FSM and the datapath.
//   opcode, zero      : datapath -> controller (IR[31:26], ALU zero flag)
//   control strobes   : controller -> datapath (mux selects, write enables)
//   halted, state,
//   instr_count       : controller status / debug
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        pc_en;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        zero_ext;
  logic [1:0]  pc_source;
  logic [2:0]  alu_op;
  logic        halted;
  logic [3:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  opcode, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, zero_ext, pc_source, alu_op,
           halted, state, instr_count
  );

  modport slave (
    output opcode, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, zero_ext, pc_source, alu_op,
           halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_ctr.sv
// mem_wait_ctr: counts the cycles spent in a memory-access state.
//   clk, rst_n : clock, async active-low reset
//   start      : state entry; counter reloads to 0 on this edge
//   done       : current cycle is the last one (count == MEM_LATENCY)
//   done_next  : the cycle after the coming edge will be the last one; lets
//                the FSM register last-cycle strobes one edge ahead
module mem_wait_ctr #(
  parameter int MEM_LATENCY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done,
  output logic done_next
);

  localparam logic [4:0] LAT = 5'(MEM_LATENCY);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done      = ({1'b0, cnt} == LAT);
  assign done_next = start ? (LAT == 5'd0) : (({1'b0, cnt} + 5'd1) == LAT);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the shared multi-cycle MIPS datapath.
//   clk, rst_n : clock, async active-low reset
//   bus        : multicycle_ctrl_if.master (opcode/zero in, controls out)
// Control outputs are registered from the next state, so they line up with
// the state they belong to. The one exception is pc_en in BRANCH, which must
// follow the zero flag produced during that same cycle.
//
// state     | meaning
// IDLE      | one cycle after reset, all outputs low
// FETCH     | read instruction at PC, PC+4; IR/PC load on last wait cycle
// DECODE    | latch opcode, precompute branch target
// MEM_ADDR  | A + imm for lw/sw
// MEM_READ  | data read at ALUOut, waits MEM_LATENCY+1 cycles
// MEM_WB    | rt <= MDR, retire
// MEM_WRITE | data write at ALUOut, retire on last wait cycle
// R_EXEC    | A funct B
// R_WB      | rd <= ALUOut, retire
// BRANCH    | compare A/B, PC <= target if taken, retire
// JUMP      | PC <= jump target, retire
// I_EXEC    | A op imm
// I_WB      | rt <= ALUOut, retire
// HALT      | unsupported opcode, frozen until reset
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q;
  logic        halted_q;
  logic [5:0]  op_q;
  logic [31:0] count_q;
  logic        wait_start, wait_done, wait_done_next;
  logic        retire, branch_taken;

  mem_wait_ctr #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wait_start),
    .done      (wait_done),
    .done_next (wait_done_next)
  );

  assign wait_start = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:                         state_d = S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default:                          state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = wait_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = wait_done ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  assign retire = (state_q inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB}) ||
                  (state_q == S_MEM_WRITE && wait_done);

  // Control word for state s; last marks the final wait cycle of FETCH.
  function automatic ctrl_t decode(state_e s, logic last, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_source = PCSRC_ALU;
        c.alu_op    = ALU_ADD;
        c.ir_write  = last;
        c.pc_en     = last;
      end
      S_DECODE:    c.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_en     = 1'b1;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: begin c.alu_op = ALU_AND; c.zero_ext = 1'b1; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.zero_ext = 1'b1; end
          OP_SLTI: c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB:      c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
      op_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      // I_EXEC is only entered from DECODE, where the live opcode is valid.
      ctrl_q   <= decode(state_d, wait_done_next,
                         (state_q == S_DECODE) ? bus.opcode : op_q);
      halted_q <= (state_d == S_HALT);
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  // bne takes the branch on ~zero: zero XOR is_bne.
  assign branch_taken = (state_q == S_BRANCH) && (bus.zero ^ (op_q == OP_BNE));

  assign bus.pc_en       = ctrl_q.pc_en | branch_taken;
  assign bus.iord        = ctrl_q.iord;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.ir_write    = ctrl_q.ir_write;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.zero_ext    = ctrl_q.zero_ext;
  assign bus.pc_source   = ctrl_q.pc_source;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.halted      = halted_q;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main control FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, IR/MDR/A/B/ALUOut registers.
- Sits beside the datapath in the multi-cycle variant of the processor.
- Drives every mux select and write enable from the current state.
- Inserts programmable memory wait cycles.
- Counts retired instructions and halts on an unsupported opcode.

Parameters:
- MEM_LATENCY, 0, extra wait cycles per memory access (0..15); the access completes on cycle MEM_LATENCY+1 of the state.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from the DECODE state onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- pc_en  out  1  PC load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  register write data select: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- zero_ext  out  1  1 = zero-extend imm (andi/ori)
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- halted  out  1  FSM is in HALT
- state  out  4  current state code (debug)
- instr_count  out  32  retired instruction count

Behaviour:
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, HALT 13.
- Reset (rst_n low, asynchronous):
  - state = IDLE, wait counter = 0, instr_count = 0, latched opcode = 0.
  - All control outputs 0, halted = 0.
- IDLE -> FETCH unconditionally on the first clk edge after reset release. Every output is 0 in IDLE.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 00.
  - Stays for MEM_LATENCY+1 cycles, counted by the wait counter.
  - ir_write and pc_en assert only on the last cycle, then -> DECODE.
- DECODE:
  - Latch opcode.
  - alu_src_a = 0, alu_src_b = 11, alu_op = 000 (branch target precompute).
  - Next state by opcode:
    - 0x00 -> R_EXEC
    - 0x23, 0x2B -> MEM_ADDR
    - 0x04, 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x08, 0x0C, 0x0D, 0x0A -> I_EXEC
    - any other opcode -> HALT
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read = 1, iord = 1; waits MEM_LATENCY+1 cycles -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires, -> FETCH.
- MEM_WRITE: mem_write = 1, iord = 1 for all MEM_LATENCY+1 cycles. Retires on the last cycle, -> FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 010 -> R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retires, -> FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_source = 01.
  - pc_en = zero for beq (0x04), pc_en = ~zero for bne (0x05).
  - Retires, -> FETCH.
- JUMP: pc_source = 10, pc_en = 1. Retires, -> FETCH.
- I_EXEC:
  - alu_src_a = 1, alu_src_b = 10.
  - alu_op by opcode: addi 000, andi 011, ori 100, slti 101.
  - zero_ext = 1 for andi and ori only.
  - -> I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires, -> FETCH. zero_ext is not required here.
- HALT: all controls 0, halted = 1. Absorbing until reset; instr_count frozen.
- "Retires" means instr_count += 1 on the exit edge of that state. The counter wraps at 2^32 with no flag.
- Cycles per instruction (MEM_LATENCY = L): R 4+L, lw 5+2L, sw 4+2L, beq/bne 3+L, j 3+L, I-type 4+L.
- Reset asserted mid-instruction aborts it:
  - No further strobes; instr_count clears.
  - The in-flight instruction is not counted.
- The wait counter reloads to 0 on every state entry. Strobes remain asserted throughout the wait.

Decomposition:
- Shared package `ctrl_pkg`:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI
  - alu_op and alu_src_b / pc_source encodings
- One sub-module, `mem_wait_ctr`: wait counter with `start` and `done` outputs, parameterised by MEM_LATENCY.
- The FSM next-state and output decode stay in multicycle_ctrl.

Test Plan:
- Reset: rst_n low for 3 cycles, then release.
  - Required: state 0 -> 1 on the first edge.
  - mem_read = 1 in FETCH; all other outputs 0 during reset.
- L = 0, opcode 0x00 (add).
  - Required: states 1, 2, 7, 8, 1.
  - reg_write = 1 only in R_WB; instr_count = 1 after 4 cycles.
- L = 2, opcode 0x23 (lw).
  - Required: FETCH 3 cycles, ir_write high only on the 3rd; MEM_READ 3 cycles with iord = 1.
  - Total 9 cycles; mem_to_reg = 1 in MEM_WB.
- L = 0, opcode 0x04 with zero = 1, then 0x05 with zero = 1.
  - Required: pc_en = 1 in the first BRANCH, 0 in the second.
  - instr_count increments by 2.
- L = 0, opcode 0x0D (ori).
  - Required: alu_op = 100 and zero_ext = 1 in I_EXEC.
  - reg_dst = 0 and reg_write = 1 in I_WB.
- L = 0, opcode 0x3F.
  - Required: DECODE -> HALT, halted = 1, state = 13, instr_count unchanged for 10 cycles.
  - Then rst_n pulse -> IDLE, instr_count = 0.
